// File: rtl/kmeans_pkg.sv
// Shared constants, FSM state and label type for the k-means centroid update stage.
package kmeans_pkg;

  localparam int unsigned CONF_K = 4;
  localparam int unsigned CONF_N = 4096;
  localparam int unsigned DW     = 16;
  localparam int unsigned CW     = 13;
  localparam int unsigned SW     = 28;
  localparam int unsigned LW     = $clog2(CONF_K);

  typedef enum logic [2:0] {ACC, SEL, DIVX, DIVY, EMIT} state_t;

  typedef logic [LW-1:0] label_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses SW+1 cycles after start.
module seq_divider
  import kmeans_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  input  logic [CW-1:0] divisor,
  output logic          done,
  output logic [SW-1:0] quotient
);

  localparam int unsigned BW = $clog2(SW + 1);

  logic [SW-1:0] q_q;
  logic [CW-1:0] rem_q;
  logic [BW-1:0] bits_q;
  logic          busy_q;
  logic          done_q;
  logic [CW:0]   shifted;
  logic [CW-1:0] diff;
  logic          ge;

  // Remainder stays below divisor, so the shifted value fits CW+1 bits and the
  // restored remainder fits CW bits.
  always_comb begin
    shifted = {rem_q, q_q[SW-1]};
    ge      = shifted >= {1'b0, divisor};
    diff    = shifted[CW-1:0] - divisor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      rem_q  <= '0;
      bits_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        q_q    <= dividend;
        rem_q  <= '0;
        bits_q <= BW'(SW);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        q_q    <= {q_q[SW-2:0], ge};
        rem_q  <= ge ? diff : shifted[CW-1:0];
        bits_q <= bits_q - BW'(1);
        if (bits_q == BW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = q_q;

endmodule

// File: rtl/kmeans_centroid_update.sv
// Accumulates labelled points per cluster, then emits floor(sum/count) centroids in label order.
module kmeans_centroid_update
  import kmeans_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x,
  input  logic [DW-1:0] in_y,
  input  label_t        in_label,
  input  logic          in_last,
  output logic          out_valid,
  output label_t        out_label,
  output logic [DW-1:0] out_x,
  output logic [DW-1:0] out_y,
  output logic          out_empty,
  output logic          out_done,
  output logic          overflow
);

  localparam logic [CW-1:0] NMAX  = CW'(CONF_N);
  localparam label_t        LAST_P = label_t'(CONF_K - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] sum_x_q [CONF_K];
  logic [SW-1:0] sum_y_q [CONF_K];
  logic [CW-1:0] cnt_q   [CONF_K];
  logic [CW-1:0] total_q;
  label_t        ptr_q;
  logic          frame_start_q;
  logic          overflow_q;
  logic [DW-1:0] x_lat_q;
  label_t        out_label_q;
  logic [DW-1:0] out_x_q, out_y_q;
  logic          out_empty_q;

  logic          hs;
  logic          cur_empty;
  logic          last_ptr;
  logic          div_start, div_done;
  logic [SW-1:0] div_dividend, div_quotient;
  logic          unused_quot_hi;

  assign hs             = in_valid & in_ready;
  assign cur_empty      = (cnt_q[ptr_q] == '0);
  assign last_ptr       = (ptr_q == LAST_P);
  assign unused_quot_hi = ^div_quotient[SW-1:DW];

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_done     = 1'b0;
    div_start    = 1'b0;
    div_dividend = sum_x_q[ptr_q];
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (hs && in_last) state_d = SEL;
      end
      SEL: begin
        if (cur_empty) begin
          state_d = EMIT;
        end else begin
          div_start = 1'b1;
          state_d   = DIVX;
        end
      end
      DIVX: begin
        // The y division starts in the same cycle the x quotient is available.
        if (div_done) begin
          div_start    = 1'b1;
          div_dividend = sum_y_q[ptr_q];
          state_d      = DIVY;
        end
      end
      DIVY: begin
        if (div_done) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_done  = last_ptr;
        state_d   = last_ptr ? ACC : SEL;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACC;
      total_q       <= '0;
      ptr_q         <= '0;
      frame_start_q <= 1'b1;
      overflow_q    <= 1'b0;
      x_lat_q       <= '0;
      out_label_q   <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_empty_q   <= 1'b0;
      for (int i = 0; i < CONF_K; i++) begin
        sum_x_q[i] <= '0;
        sum_y_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        ACC: begin
          if (hs) begin
            if (frame_start_q) begin
              overflow_q    <= 1'b0;
              frame_start_q <= 1'b0;
            end
            if (total_q == NMAX) begin
              overflow_q <= 1'b1;
            end else begin
              sum_x_q[in_label] <= sum_x_q[in_label] + SW'(in_x);
              sum_y_q[in_label] <= sum_y_q[in_label] + SW'(in_y);
              cnt_q[in_label]   <= cnt_q[in_label] + CW'(1);
              total_q           <= total_q + CW'(1);
            end
          end
        end
        SEL: begin
          if (cur_empty) begin
            out_label_q <= ptr_q;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_empty_q <= 1'b1;
          end
        end
        DIVX: begin
          if (div_done) x_lat_q <= div_quotient[DW-1:0];
        end
        DIVY: begin
          if (div_done) begin
            out_label_q <= ptr_q;
            out_x_q     <= x_lat_q;
            out_y_q     <= div_quotient[DW-1:0];
            out_empty_q <= 1'b0;
          end
        end
        EMIT: begin
          if (last_ptr) begin
            ptr_q         <= '0;
            total_q       <= '0;
            frame_start_q <= 1'b1;
            for (int i = 0; i < CONF_K; i++) begin
              sum_x_q[i] <= '0;
              sum_y_q[i] <= '0;
              cnt_q[i]   <= '0;
            end
          end else begin
            ptr_q <= ptr_q + label_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (cnt_q[ptr_q]),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign out_label = out_label_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_empty = out_empty_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Directed bench with a scoreboard of expected centroid pulses, including their cycle of arrival.
module tb_kmeans_centroid_update;
  import kmeans_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x, in_y;
  label_t        in_label;
  logic          in_last;
  logic          out_valid;
  label_t        out_label;
  logic [DW-1:0] out_x, out_y;
  logic          out_empty, out_done, overflow;

  kmeans_centroid_update dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_label  (in_label),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_label (out_label),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_empty (out_empty),
    .out_done  (out_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  label;
    logic [15:0] x;
    logic [15:0] y;
    logic        empty;
    logic        done;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  longint      msx[4], msy[4];
  int          mcnt[4];
  int          mtotal;
  bit          movf;
  bit          mframe_start;
  int unsigned last_emit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      msx[k]  = 0;
      msy[k]  = 0;
      mcnt[k] = 0;
    end
    mtotal = 0;
  endtask

  task automatic model_reset();
    model_clear();
    movf         = 1'b0;
    mframe_start = 1'b1;
    sb.delete();
  endtask

  // Expected pulses: nonempty cluster takes 60 cycles from SEL to EMIT, empty takes 2.
  task automatic finish_frame(input int unsigned h);
    exp_t        e;
    int unsigned t;
    t = h;
    for (int k = 0; k < 4; k++) begin
      t       += (mcnt[k] != 0) ? 60 : 2;
      e.label  = 2'(k);
      e.empty  = (mcnt[k] == 0);
      e.x      = (mcnt[k] == 0) ? 16'd0 : 16'(msx[k] / mcnt[k]);
      e.y      = (mcnt[k] == 0) ? 16'd0 : 16'(msy[k] / mcnt[k]);
      e.done   = (k == 3);
      e.cyc    = t;
      sb.push_back(e);
    end
    last_emit    = t;
    model_clear();
    mframe_start = 1'b1;
  endtask

  // Called #1 after a posedge while the DUT is in ACC; returns #1 after the handshake edge.
  task automatic send(input int x, input int y, input int l, input bit last);
    int unsigned h;
    in_valid = 1'b1;
    in_x     = x[15:0];
    in_y     = y[15:0];
    in_label = l[1:0];
    in_last  = last;
    h        = cyc;
    chk("in_ready_acc", in_ready, 1);
    if (mframe_start) begin
      movf         = 1'b0;
      mframe_start = 1'b0;
    end
    if (mtotal < CONF_N) begin
      msx[l]  += x;
      msy[l]  += y;
      mcnt[l] += 1;
      mtotal  += 1;
    end else begin
      movf = 1'b1;
    end
    if (last) finish_frame(h);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("overflow", overflow, movf);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
    chk("ready_after_done", in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_label", out_label, mon_e.label);
        chk("out_x", out_x, mon_e.x);
        chk("out_y", out_y, mon_e.y);
        chk("out_empty", out_empty, mon_e.empty);
        chk("out_done", out_done, mon_e.done);
        chk("out_cycle", cyc, mon_e.cyc);
      end
    end
    if (!rst && out_done && !out_valid) chk("stray_done", 1, 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          nv;
    int unsigned h;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_label = '0;
    in_last  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_empty", out_empty, 0);
    chk("rst_out_done", out_done, 0);
    chk("rst_overflow", overflow, 0);

    // Two identical points in cluster 0, others empty.
    send(1024, 512, 0, 1'b0);
    send(1024, 512, 0, 1'b1);
    chk("ready_low_sel", in_ready, 0);
    wait_drain();

    // Floor rounding: y = 31/2.
    send(1, 10, 1, 1'b0);
    send(2, 21, 1, 1'b1);
    wait_drain();

    // Full frame plus one dropped point; a counted (0,0) would pull the mean down.
    for (int i = 0; i <= 4096; i++) begin
      if (i < 4096) send(65535, 65535, 3, 1'b0);
      else          send(0, 0, 3, 1'b1);
    end
    chk("overflow_set", overflow, 1);
    wait_drain();
    chk("overflow_sticky", overflow, 1);

    // Back-to-back frames with in_valid held high while the block is busy.
    send(100, 100, 0, 1'b0);
    chk("overflow_cleared", overflow, 0);
    send(200, 300, 0, 1'b1);
    in_valid = 1'b1;
    in_x     = 16'd60000;
    in_y     = 16'd60000;
    in_label = 2'd1;
    in_last  = 1'b1;
    while (cyc < last_emit) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain();
    send(5, 5, 1, 1'b0);
    send(8, 4, 3, 1'b1);
    wait_drain();

    // One point per label, pulses 60 cycles apart.
    for (int k = 0; k < 4; k++) send(k * 100, k * 200, k, k == 3);
    wait_drain();

    // Reset during the y division of cluster 2.
    send(10, 20, 0, 1'b0);
    send(30, 40, 1, 1'b0);
    h = cyc;
    send(50, 60, 2, 1'b1);
    for (int i = 0; i < 400 && cyc < h + 165; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_divy", cyc, h + 165);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_valid", out_valid, 0);
    nv = 0;
    repeat (200) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("no_out_after_rst", nv, 0);
    @(posedge clk);
    #1;
    send(7, 9, 2, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
